// File: rtl/axi_adf4030_bsync_receiver_pkg.sv
// Shared definitions for the ADF4030 BSYNC link: the state encoding seen by
// the generator, the receiver and the register map.
package adf4030_bsync_pkg;

  localparam int BSYNC_STATE_W = 3;

  typedef enum logic [BSYNC_STATE_W-1:0] {
    BSYNC_IDLE    = 3'd0,
    BSYNC_SEEK    = 3'd1,
    BSYNC_MEASURE = 3'd2,
    BSYNC_VERIFY  = 3'd3,
    BSYNC_LOCKED  = 3'd4,
    BSYNC_ERROR   = 3'd5
  } bsync_state_t;

endpackage

// File: rtl/axi_adf4030_bsync_receiver_if.sv
// Control and status bundle of the BSYNC receiver. The master side drives
// enable/bsync/ratio/clear, the slave side (the receiver) returns status.
interface axi_adf4030_bsync_receiver_if
  import adf4030_bsync_pkg::*;
#(
  parameter int RATIO_WIDTH = 16
) ();

  logic                     enable;
  logic                     bsync_in;
  logic [RATIO_WIDTH-1:0]   expected_ratio;
  logic                     error_clear;
  logic                     bsync_event;
  logic                     bsync_captured;
  logic                     bsync_locked;
  logic                     bsync_alignment_error;
  logic [RATIO_WIDTH-1:0]   measured_ratio;
  logic [RATIO_WIDTH-1:0]   bsync_phase;
  logic [BSYNC_STATE_W-1:0] bsync_state;

  modport master (
    output enable, bsync_in, expected_ratio, error_clear,
    input  bsync_event, bsync_captured, bsync_locked, bsync_alignment_error,
    input  measured_ratio, bsync_phase, bsync_state
  );

  modport slave (
    input  enable, bsync_in, expected_ratio, error_clear,
    output bsync_event, bsync_captured, bsync_locked, bsync_alignment_error,
    output measured_ratio, bsync_phase, bsync_state
  );

endinterface

// File: rtl/axi_adf4030_bsync_receiver_edge_detect.sv
// Two-flop sampler of BSYNC plus a registered rising-edge pulse. The raw
// (combinational) rise is exported so the FSM acts in the same cycle the
// pulse register is loaded.
module bsync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic en,
  output logic rise,
  output logic pulse
);

  logic sync_p0;
  logic sync_p1;

  // sample stage p0, history stage p1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  assign rise = sync_p0 & ~sync_p1;

  // registered event pulse, suppressed while the receiver is disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pulse <= 1'b0;
    else     pulse <= rise & en;
  end

endmodule

// File: rtl/axi_adf4030_bsync_receiver.sv
// ADF4030 BSYNC receiver: measures the BSYNC period, qualifies lock over
// consecutive equal periods, then runs a flywheel phase counter and flags
// misplaced or missing edges with a sticky error.
module axi_adf4030_bsync_receiver
  import adf4030_bsync_pkg::*;
#(
  parameter int RATIO_WIDTH = 16,
  parameter int LOCK_COUNT  = 4
) (
  input logic clk,
  input logic rst,
  axi_adf4030_bsync_receiver_if.slave bus
);

  localparam logic [2:0] ST_IDLE    = 3'(BSYNC_IDLE);
  localparam logic [2:0] ST_SEEK    = 3'(BSYNC_SEEK);
  localparam logic [2:0] ST_MEASURE = 3'(BSYNC_MEASURE);
  localparam logic [2:0] ST_VERIFY  = 3'(BSYNC_VERIFY);
  localparam logic [2:0] ST_LOCKED  = 3'(BSYNC_LOCKED);
  localparam logic [2:0] ST_ERROR   = 3'(BSYNC_ERROR);
  localparam int MATCH_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;

  logic                   rise;
  logic [2:0]             state, state_nxt;
  logic [RATIO_WIDTH-1:0] cnt, cand, ratio, phase;
  logic [MATCH_W-1:0]     match;
  logic                   captured, locked, err;
  logic                   to_error, take_cand, match_inc, lock_now;
  logic                   sat, wrap;

  bsync_edge_detect u_edge (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.bsync_in),
    .en    (bus.enable),
    .rise  (rise),
    .pulse (bus.bsync_event)
  );

  // a saturated counter means the next edge never arrived
  assign sat  = (cnt == '1);
  assign wrap = (phase == ratio - RATIO_WIDTH'(1));

  // next-state decision and the qualification events that go with it
  always_comb begin
    state_nxt = state;
    to_error  = 1'b0;
    take_cand = 1'b0;
    match_inc = 1'b0;
    lock_now  = 1'b0;
    if (!bus.enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_SEEK;
        ST_SEEK: if (rise) state_nxt = ST_MEASURE;
        ST_MEASURE: begin
          if (sat) to_error = 1'b1;
          else if (rise) begin
            if (cnt < RATIO_WIDTH'(2) ||
                (bus.expected_ratio != '0 && cnt != bus.expected_ratio))
              to_error = 1'b1;
            else
              take_cand = 1'b1;
          end
        end
        ST_VERIFY: begin
          if (sat) to_error = 1'b1;
          else if (rise) begin
            if (cnt != cand)                         to_error = 1'b1;
            else if (match == MATCH_W'(LOCK_COUNT - 1)) lock_now = 1'b1;
            else                                     match_inc = 1'b1;
          end
        end
        // once locked, an edge must coincide exactly with the phase wrap
        ST_LOCKED: if (rise != wrap) to_error = 1'b1;
        ST_ERROR:  if (bus.error_clear) state_nxt = ST_SEEK;
        default:   state_nxt = ST_IDLE;
      endcase
      if (take_cand) state_nxt = ST_VERIFY;
      if (lock_now)  state_nxt = ST_LOCKED;
      if (to_error)  state_nxt = ST_ERROR;
    end
  end

  // state, period counter, qualification and flywheel registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cand     <= '0;
      ratio    <= '0;
      phase    <= '0;
      match    <= '0;
      captured <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!bus.enable) begin
        cnt      <= '0;
        phase    <= '0;
        match    <= '0;
        captured <= 1'b0;
        locked   <= 1'b0;
      end else begin
        cnt      <= rise ? RATIO_WIDTH'(1) : (sat ? cnt : cnt + RATIO_WIDTH'(1));
        captured <= captured | rise;
        locked   <= (state_nxt == ST_LOCKED);
        if (take_cand) begin
          cand  <= cnt;
          match <= '0;
        end
        if (match_inc) match <= match + MATCH_W'(1);
        if (lock_now)  ratio <= cnt;
        // phase 0 is aligned to the locking edge, then free-runs
        if (state_nxt != ST_LOCKED || lock_now) phase <= '0;
        else phase <= wrap ? '0 : phase + RATIO_WIDTH'(1);
      end
    end
  end

  // sticky alignment error: a new error wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else     err <= to_error | (err & ~bus.error_clear);
  end

  assign bus.bsync_captured        = captured;
  assign bus.bsync_locked          = locked;
  assign bus.bsync_alignment_error = err;
  assign bus.measured_ratio        = ratio;
  assign bus.bsync_phase           = phase;
  assign bus.bsync_state           = state;

endmodule

// File: tb/tb_axi_adf4030_bsync_receiver.sv
// Bench for the BSYNC receiver: a pattern generator drives BSYNC, a
// timestamp-based reference model predicts every output each cycle.
module tb_axi_adf4030_bsync_receiver;

  localparam int RW = 16;
  localparam int LC = 4;
  localparam int M_IDLE = 0, M_SEEK = 1, M_MEAS = 2, M_VER = 3, M_LOCK = 4, M_ERR = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_adf4030_bsync_receiver_if #(.RATIO_WIDTH(RW)) bus ();

  axi_adf4030_bsync_receiver #(.RATIO_WIDTH(RW), .LOCK_COUNT(LC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference model: edges are timestamps, periods are differences
  bit p1, p2;
  int m_mode, m_last, m_cand, m_match, m_lock_t, m_ratio;
  bit m_err, m_cap, m_ev;
  int rises;

  function automatic int m_phase();
    return (m_mode == M_LOCK) ? (cyc - m_lock_t) % m_ratio : 0;
  endfunction

  task automatic model_reset();
    p1 = 0; p2 = 0;
    m_mode = M_IDLE; m_last = 0; m_cand = 0; m_match = 0;
    m_lock_t = 0; m_ratio = 0; m_err = 0; m_cap = 0; m_ev = 0;
  endtask

  task automatic model_step(input bit en, input bit clr, input int ex, input bit din);
    bit rise, fail;
    int per;
    rise = p1 && !p2;
    p2 = p1; p1 = din;
    cyc++;
    fail = 0;
    per = cyc - m_last;
    m_ev = en && rise;
    if (rise) rises++;
    if (!en) begin
      m_mode = M_IDLE;
      m_cap = 0;
    end else begin
      if (rise) m_cap = 1;
      case (m_mode)
        M_IDLE: m_mode = M_SEEK;
        M_SEEK: if (rise) begin m_mode = M_MEAS; m_last = cyc; end
        M_MEAS, M_VER: begin
          if (per >= (1 << RW) - 1) fail = 1;
          else if (rise) begin
            if (m_mode == M_MEAS) begin
              if (per < 2 || (ex != 0 && per != ex)) fail = 1;
              else begin m_cand = per; m_match = 0; m_mode = M_VER; end
            end else if (per != m_cand) begin
              fail = 1;
            end else begin
              m_match++;
              if (m_match == LC) begin m_mode = M_LOCK; m_ratio = per; m_lock_t = cyc; end
            end
            m_last = cyc;
          end
        end
        M_LOCK: if (rise != ((cyc - m_lock_t) % m_ratio == 0)) fail = 1;
        M_ERR:  if (clr) m_mode = M_SEEK;
        default: ;
      endcase
      if (fail) m_mode = M_ERR;
    end
    m_err = fail || (m_err && !clr);
  endtask

  // BSYNC pattern generator
  int gc, g_p, g_w, g_glitch;
  bit g_mute;

  function automatic bit gen_bit();
    return (!g_mute && (gc % g_p) < g_w) || (gc == g_glitch);
  endfunction

  task automatic plan_glitch();
    int base;
    base = ((gc / g_p) + 3) * g_p;
    g_glitch = base + g_w + 1 + int'($urandom % (g_p - 2 - g_w));
  endtask

  task automatic check_all();
    chk("event",    bus.bsync_event, m_ev);
    chk("captured", bus.bsync_captured, m_cap);
    chk("locked",   bus.bsync_locked, (m_mode == M_LOCK));
    chk("error",    bus.bsync_alignment_error, m_err);
    chk("ratio",    bus.measured_ratio, m_ratio);
    chk("phase",    bus.bsync_phase, m_phase());
    chk("state",    bus.bsync_state, m_mode);
  endtask

  task automatic step(input bit en, input bit clr, input int ex);
    bit din;
    din = gen_bit();
    gc++;
    bus.enable = en;
    bus.error_clear = clr;
    bus.expected_ratio = RW'(ex);
    bus.bsync_in = din;
    model_step(en, clr, ex, din);
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n, input int ex);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, ex);
  endtask

  initial begin
    int lock_edge, guard;
    bit seen_locked, clr;

    rst = 1'b1;
    bus.enable = 0; bus.bsync_in = 0; bus.expected_ratio = '0; bus.error_clear = 0;
    model_reset();
    g_p = 16; g_w = 1; g_glitch = -1; g_mute = 0; gc = 0;
    repeat (3) @(negedge clk);
    check_all();
    rst = 1'b0;

    // period 16, free ratio: lock on the 6th edge
    g_w = 1 + int'($urandom % 6);
    gc = int'($urandom % 16);
    rises = 0; lock_edge = 0;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'b0, 0);
      if (bus.bsync_locked && lock_edge == 0) lock_edge = rises;
    end
    chk("lock_edge", lock_edge, 6);
    chk("ratio16", bus.measured_ratio, 16);

    // extra edge while locked, cleared in the very cycle the error is raised
    plan_glitch();
    for (int i = 0; i < 60; i++) begin
      clr = p1 && !p2 && m_mode == M_LOCK && ((cyc + 1 - m_lock_t) % m_ratio != 0);
      step(1'b1, clr, 0);
    end
    chk("glitch_err", bus.bsync_alignment_error, 1);
    chk("glitch_state", bus.bsync_state, M_ERR);
    step(1'b1, 1'b1, 0);
    chk("clr_state", bus.bsync_state, M_SEEK);
    run(200, 0);
    chk("relock", bus.bsync_locked, 1);

    // bsync held low while locked
    g_mute = 1;
    run(40, 0);
    chk("missing_err", bus.bsync_alignment_error, 1);
    chk("missing_state", bus.bsync_state, M_ERR);
    g_mute = 0;

    // wrong expected ratio: error at the second edge, never locks
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 0);
    seen_locked = 0;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'b0, 20);
      if (bus.bsync_locked) seen_locked = 1;
    end
    chk("never_locked", seen_locked, 0);
    chk("ratio_err", bus.bsync_alignment_error, 1);

    // enable dropped mid-VERIFY
    step(1'b0, 1'b1, 0);
    guard = 0;
    while (m_mode != M_VER && guard < 100) begin
      step(1'b1, 1'b0, 0);
      guard++;
    end
    chk("reach_verify", (guard < 100), 1);
    step(1'b0, 1'b0, 0);
    chk("drop_state", bus.bsync_state, M_IDLE);
    chk("drop_captured", bus.bsync_captured, 0);

    // randomized rounds
    for (int r = 0; r < 12; r++) begin
      int ex, sel;
      g_p = 4 + int'($urandom % 37);
      g_w = 1 + int'($urandom % (g_p - 3));
      sel = int'($urandom % 4);
      ex = (sel == 0) ? g_p + 1 + int'($urandom % 5) : ((sel == 1) ? g_p : 0);
      plan_glitch();
      if ($urandom % 2 == 0) g_glitch += 10 * g_p;
      for (int i = 0; i < 300; i++) begin
        if ($urandom % 150 == 0) g_mute = ~g_mute;
        step(($urandom % 200) != 0, ($urandom % 50) == 0, ex);
      end
      g_mute = 0;
    end

    // asynchronous reset while locked
    g_p = 16; g_w = 2;
    step(1'b0, 1'b1, 0);
    run(200, 0);
    chk("pre_rst_locked", bus.bsync_locked, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_event", bus.bsync_event, 0);
    chk("rst_locked", bus.bsync_locked, 0);
    chk("rst_captured", bus.bsync_captured, 0);
    chk("rst_error", bus.bsync_alignment_error, 0);
    chk("rst_ratio", bus.measured_ratio, 0);
    chk("rst_phase", bus.bsync_phase, 0);
    chk("rst_state", bus.bsync_state, M_IDLE);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(150, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
